ecc_serial_frontend: RTL and testbench
======================================

# ecc_serial_frontend

Parametrised bit-serial front end for the ECC point-multiplication core. It deserialises a mode header and MSB-first operands from a configurable number of 1-bit input lanes into right-justified parallel registers. It launches the core through a start/ready handshake, then serialises the core's results MSB-first on a configurable number of 1-bit output lanes. It keeps the curve context between jobs, so follow-up jobs reload only the point lanes.

## Interface
- MAX_BITS, 128: operand register width; power of two, at least 16.
- N_IN, 6: serial input lanes (a, b, prime, Px, Py, m in the default build).
- N_OUT, 2: serial output lanes (Px, Py).
- RELOAD_MASK, 6'b011000: input lanes reloaded by a context job (bit k set = lane k reloaded).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_data_valid  in  1  one-cycle job start pulse.
- i_mode  in  1  width-code header bits, MSB first.
- i_data  in  N_IN  serial operand bits, one bit per lane per cycle.
- o_data_valid  out  1  high in the cycle carrying the first result bit.
- o_data  out  N_OUT  serial result bits.
- o_busy  out  1  high in every state except IDLE.
- core_start  out  1  request to the core; held until accepted.
- core_ready  in  1  core accepts the request when high together with core_start.
- core_reload  out  1  high with core_start on context jobs.
- core_bits  out  2  latched width code.
- core_operand  out  N_IN*MAX_BITS  lane k occupies bits [k*MAX_BITS +: MAX_BITS].
- core_done  in  1  one-cycle completion pulse.
- core_result  in  N_OUT*MAX_BITS  valid in the core_done cycle.

## Operation
- States: IDLE, MODE1, MODE0, LOAD, START, WAIT, OUT.
- Operand width W = 16 << code for code 00..11 (16/32/64/128). Any W larger than MAX_BITS is clamped to MAX_BITS.
- Context flag ctx: cleared by reset; set when a full job's LOAD completes.
- IDLE with i_data_valid, ctx=0 (full job): go to MODE1.
- MODE1 samples i_mode into code[1]; MODE0 samples code[0].
- Entering LOAD clears all lane registers and the bit counter.
- IDLE with i_data_valid, ctx=1 (context job): go directly to LOAD.
  - Reuses the latched code.
  - Clears only the lanes selected by RELOAD_MASK; the other lanes and their i_data bits are frozen.
- LOAD: for W cycles, each active lane register does reg <= {reg[MAX_BITS-2:0], i_data[k]}. The first bit received becomes bit W-1; upper bits stay 0.
- START: core_start=1 and core_reload=!first_job until core_ready=1, then go to WAIT. core_operand and core_bits are stable from START through WAIT.
- WAIT: on core_done, latch core_result into the output shifters and go to OUT. core_done is ignored in every other state.
- OUT: for W cycles, o_data[j] = bit (W-1-n) of result lane j, n = 0..W-1. o_data_valid=1 only for n=0. Then go to IDLE.
- i_data_valid is ignored in every state except IDLE.

## Timing
- Reset values: state IDLE, ctx=0, code=00, lane and result registers 0. All outputs 0.
- Let cycle 0 be the cycle where i_data_valid is sampled.
- Full job: i_mode is sampled in cycles 1 and 2; data bits in cycles 3..W+2; core_start first high in cycle W+3.
- Context job: data bits are sampled in cycles 1..W; core_start first high in cycle W+1.
- If core_done is sampled in cycle d, the first result bit and o_data_valid appear in cycle d+1 and the last bit in cycle d+W. o_busy falls in cycle d+W+1.
- A new i_data_valid is accepted in cycle d+W+1 at the earliest.
- Zero-wait handshake: core_ready high in the first START cycle means exactly one core_start cycle.
- rst asserted in any state returns everything to reset values immediately, drops core_start, and clears ctx. The next job must be a full job.
- Between jobs, o_data holds 0 outside OUT.

## Test plan
- Full 16-bit job: code 00, lanes a=0x0003, prime=0x0017, Px=0x0005, Py=0x000A, m=0x0009, core_ready=1. Required: core_operand lanes match right-justified with zero upper bits; core_start is a single pulse in cycle 19; core_reload=0.
- Context job after the first: only Px/Py lanes change to 0x000C/0x0011. Required: a, b, prime, m unchanged; core_reload=1; core_start in cycle 17.
- 128-bit job returning core_result Px=0x0123...EF, Py=0xFEDC...10. Required: o_data_valid high in exactly one cycle, 128 MSB-first bits on o_data that reassemble both values.
- core_ready held low for 5 cycles. Required: core_start high 6 cycles and operands stable throughout; spurious core_done pulses during LOAD are ignored.
- rst pulsed mid-LOAD and again mid-OUT. Required: all outputs 0 immediately, ctx=0, and the next i_data_valid is treated as a full job with a mode header.
- i_data_valid pulsed during WAIT and OUT. Required: no effect on state or output bits.

Source files
------------

// File: rtl/ecc_serial_frontend_if.sv
// ecc_serial_frontend_if: serial job/result lanes plus the start/ready/done handshake to the ECC core
interface ecc_serial_frontend_if #(
    parameter int MAX_BITS = 128,
    parameter int N_IN     = 6,
    parameter int N_OUT    = 2
);
    logic                      i_data_valid;
    logic                      i_mode;
    logic [N_IN-1:0]           i_data;
    logic                      o_data_valid;
    logic [N_OUT-1:0]          o_data;
    logic                      o_busy;
    logic                      core_start;
    logic                      core_ready;
    logic                      core_reload;
    logic [1:0]                core_bits;
    logic [N_IN*MAX_BITS-1:0]  core_operand;
    logic                      core_done;
    logic [N_OUT*MAX_BITS-1:0] core_result;

    modport slave (
        input  i_data_valid, i_mode, i_data, core_ready, core_done, core_result,
        output o_data_valid, o_data, o_busy, core_start, core_reload, core_bits, core_operand
    );

    modport master (
        output i_data_valid, i_mode, i_data, core_ready, core_done, core_result,
        input  o_data_valid, o_data, o_busy, core_start, core_reload, core_bits, core_operand
    );
endinterface

// File: rtl/ecc_serial_frontend.sv
// ecc_serial_frontend: deserialises jobs into core operands and serialises core results MSB-first
module ecc_serial_frontend #(
    parameter int              MAX_BITS    = 128,
    parameter int              N_IN        = 6,
    parameter int              N_OUT       = 2,
    parameter logic [N_IN-1:0] RELOAD_MASK = 6'b011000
) (
    input logic clk,
    input logic rst,
    ecc_serial_frontend_if.slave bus
);
    localparam int CW = $clog2(MAX_BITS) + 1;

    typedef enum logic [2:0] {IDLE, MODE1, MODE0, LOAD, START, WAIT, OUT} state_t;

    state_t            state, nxt;
    logic              ctx, reload, last;
    logic [1:0]        code;
    logic [CW-1:0]     cnt, w;
    logic [31:0]       w_raw;
    logic [N_IN-1:0]   act;
    logic [MAX_BITS-1:0] lane [N_IN];
    logic [MAX_BITS-1:0] res  [N_OUT];

    assign w_raw = 32'd16 << code;
    assign w     = w_raw > 32'(MAX_BITS) ? CW'(MAX_BITS) : CW'(w_raw);
    assign last  = cnt == w - 1'b1;
    assign act   = reload ? RELOAD_MASK : '1;
    assign bus.core_bits = code;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt              = state;
        bus.core_start   = 1'b0;
        bus.core_reload  = 1'b0;
        bus.o_data_valid = 1'b0;
        bus.o_busy       = state != IDLE;
        case (state)
            IDLE:  if (bus.i_data_valid) nxt = ctx ? LOAD : MODE1;
            MODE1: nxt = MODE0;
            MODE0: nxt = LOAD;
            LOAD:  if (last) nxt = START;
            START: begin
                bus.core_start  = 1'b1;
                bus.core_reload = reload;
                if (bus.core_ready) nxt = WAIT;
            end
            WAIT:  if (bus.core_done) nxt = OUT;
            OUT: begin
                bus.o_data_valid = cnt == '0;
                if (last) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.o_data       = '0;
        bus.core_operand = '0;
        for (int j = 0; j < N_OUT; j++) bus.o_data[j] = (state == OUT) & res[j][MAX_BITS-1];
        for (int k = 0; k < N_IN; k++) bus.core_operand[k*MAX_BITS +: MAX_BITS] = lane[k];
    end

    // results are pre-aligned so the first serial bit always sits in the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx    <= 1'b0;
            reload <= 1'b0;
            code   <= '0;
            cnt    <= '0;
            for (int k = 0; k < N_IN; k++) lane[k] <= '0;
            for (int j = 0; j < N_OUT; j++) res[j] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_data_valid) begin
                    reload <= ctx;
                    cnt    <= '0;
                    for (int k = 0; k < N_IN; k++) if (ctx && RELOAD_MASK[k]) lane[k] <= '0;
                end
                MODE1: code[1] <= bus.i_mode;
                MODE0: begin
                    code[0] <= bus.i_mode;
                    cnt     <= '0;
                    for (int k = 0; k < N_IN; k++) lane[k] <= '0;
                end
                LOAD: begin
                    for (int k = 0; k < N_IN; k++)
                        if (act[k]) lane[k] <= {lane[k][MAX_BITS-2:0], bus.i_data[k]};
                    cnt <= cnt + 1'b1;
                    if (last) ctx <= 1'b1;
                end
                WAIT: if (bus.core_done) begin
                    cnt <= '0;
                    for (int j = 0; j < N_OUT; j++)
                        res[j] <= bus.core_result[j*MAX_BITS +: MAX_BITS] << (CW'(MAX_BITS) - w);
                end
                OUT: begin
                    cnt <= cnt + 1'b1;
                    for (int j = 0; j < N_OUT; j++) res[j] <= res[j] << 1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_serial_frontend.sv
// tb_ecc_serial_frontend: random jobs against a value-level lane model, checked by a queue-fed monitor
module tb_ecc_serial_frontend;
    localparam int MB = 128, NI = 6, NO = 2;
    localparam logic [NI-1:0] RM = 6'b011000;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    ecc_serial_frontend_if #(.MAX_BITS(MB), .N_IN(NI), .N_OUT(NO)) bus ();
    ecc_serial_frontend #(.MAX_BITS(MB), .N_IN(NI), .N_OUT(NO), .RELOAD_MASK(RM)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {logic [NI*MB-1:0] op; logic rl; logic [1:0] bits; int st; int hold;} op_t;
    typedef struct {int w; logic [MB-1:0] px; logic [MB-1:0] py; int dc;} res_t;

    op_t  opq[$];
    res_t resq[$];
    int   checks = 0, errors = 0, cyc = 0, t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // monitor: compares handshakes and result streams against queued expectations
    logic [MB-1:0]    sh [NO];
    logic [NI*MB-1:0] snap;
    bit   coll = 0, busy_chk = 0, in_st = 0;
    int   nb = 0, st_c = 0, hold = 0;
    op_t  eo;
    res_t cr;

    always @(negedge clk) begin
        if (rst) begin
            coll = 0; in_st = 0; busy_chk = 0;
        end else begin
            if (busy_chk) begin
                chk("busy_after_out", 1024'(bus.o_busy), 1024'(0));
                busy_chk = 0;
            end
            if (bus.core_start) begin
                if (!in_st) begin
                    in_st = 1; st_c = cyc - t0; hold = 0; snap = bus.core_operand;
                end
                hold++;
                chk("operand_stable", 1024'(bus.core_operand), 1024'(snap));
                if (bus.core_ready) begin
                    in_st = 0;
                    if (opq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_start cycle=%0d", st_c);
                    end else begin
                        eo = opq.pop_front();
                        chk("core_operand", 1024'(bus.core_operand), 1024'(eo.op));
                        chk("core_reload", 1024'(bus.core_reload), 1024'(eo.rl));
                        chk("core_bits", 1024'(bus.core_bits), 1024'(eo.bits));
                        chk("start_cycle", 1024'(st_c), 1024'(eo.st));
                        chk("start_hold", 1024'(hold), 1024'(eo.hold));
                    end
                end
            end
            if (coll) begin
                chk("valid_single", 1024'(bus.o_data_valid), 1024'(0));
                for (int j = 0; j < NO; j++) sh[j] = {sh[j][MB-2:0], bus.o_data[j]};
                nb++;
            end else if (bus.o_data_valid) begin
                if (resq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid cycle=%0d", cyc - t0);
                end else begin
                    cr = resq.pop_front();
                    chk("first_bit_cycle", 1024'(cyc - t0), 1024'(cr.dc + 1));
                    for (int j = 0; j < NO; j++) sh[j] = MB'(bus.o_data[j]);
                    coll = 1; nb = 1;
                end
            end else chk("data_idle", 1024'(bus.o_data), 1024'(0));
            if (coll && nb == cr.w) begin
                chk("result_px", 1024'(sh[0]), 1024'(cr.px));
                chk("result_py", 1024'(sh[1]), 1024'(cr.py));
                coll = 0; busy_chk = 1;
            end
        end
    end

    // value-level model of the lanes and curve context
    bit            m_ctx = 0;
    logic [1:0]    m_code = '0;
    logic [MB-1:0] m_lane [NI];
    logic [MB-1:0] nv [NI];

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic int wof(input logic [1:0] c);
        int v = 16 << c;
        return v > MB ? MB : v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 1024'(bus.o_busy), 1024'(0));
        chk({tag, "_start"}, 1024'(bus.core_start), 1024'(0));
        chk({tag, "_reload"}, 1024'(bus.core_reload), 1024'(0));
        chk({tag, "_valid"}, 1024'(bus.o_data_valid), 1024'(0));
        chk({tag, "_odata"}, 1024'(bus.o_data), 1024'(0));
        chk({tag, "_bits"}, 1024'(bus.core_bits), 1024'(0));
        chk({tag, "_operand"}, 1024'(bus.core_operand), 1024'(0));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.i_data_valid = 0; bus.core_ready = 0; bus.core_done = 0;
        #1 check_reset_outputs(tag);
        m_ctx = 0; m_code = '0;
        for (int k = 0; k < NI; k++) m_lane[k] = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    // abort: 0 none, 1 reset mid-LOAD, 2 reset mid-OUT
    task automatic job(input logic [1:0] c, input int d, input bit spur,
                       input logic [MB-1:0] px, input logic [MB-1:0] py, input int abort);
        bit            full = !m_ctx;
        logic [1:0]    code = full ? c : m_code;
        int            w = wof(code);
        logic [MB-1:0] mask = (w == MB) ? '1 : ((MB'(1) << w) - 1);
        logic [NI-1:0] ld = full ? '1 : RM;
        logic [MB-1:0] val [NI];
        op_t           e;
        res_t          r;
        int            dd;
        for (int k = 0; k < NI; k++) val[k] = ld[k] ? (nv[k] & mask) : m_lane[k];
        bus.core_ready = (d == 0);
        bus.i_data_valid = 1;
        t0 = cyc;
        if (abort != 1) begin
            for (int k = 0; k < NI; k++) e.op[k*MB +: MB] = val[k];
            e.rl = !full; e.bits = code; e.st = full ? w + 3 : w + 1; e.hold = d + 1;
            opq.push_back(e);
            for (int k = 0; k < NI; k++) m_lane[k] = val[k];
            m_code = code; m_ctx = 1;
        end
        step();
        bus.i_data_valid = 0;
        if (full) begin
            bus.i_mode = code[1]; step();
            bus.i_mode = code[0]; step();
            bus.i_mode = 1'($urandom);
        end
        for (int n = 0; n < w; n++) begin
            for (int k = 0; k < NI; k++) bus.i_data[k] = ld[k] ? val[k][w-1-n] : 1'($urandom);
            if (spur) bus.core_done = 1'($urandom);
            if (abort == 1 && n == w / 2) begin
                do_reset("rst_load");
                return;
            end
            step();
        end
        bus.core_done = 0;
        bus.i_data = NI'($urandom);
        repeat (d) step();
        bus.core_ready = 1; step();
        bus.core_ready = 0;
        dd = $urandom_range(0, 4);
        repeat (dd) begin
            bus.i_data_valid = 1'($urandom);
            step();
        end
        bus.i_data_valid = 0;
        r.w = w; r.px = px & mask; r.py = py & mask; r.dc = cyc - t0;
        resq.push_back(r);
        bus.core_done = 1; bus.core_result = {py, px};
        step();
        bus.core_done = 0;
        bus.core_result = {4{$urandom(), $urandom()}};
        for (int n = 0; n < w; n++) begin
            bus.i_data_valid = 1'($urandom);
            if (abort == 2 && n == w / 2) begin
                do_reset("rst_out");
                return;
            end
            step();
        end
        bus.i_data_valid = 0;
    endtask

    function automatic logic [MB-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        bus.i_data_valid = 0; bus.i_mode = 0; bus.i_data = '0;
        bus.core_ready = 0; bus.core_done = 0; bus.core_result = '0;
        for (int k = 0; k < NI; k++) m_lane[k] = '0;
        step(); step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        nv[0] = 'h3; nv[1] = 'h0; nv[2] = 'h17; nv[3] = 'h5; nv[4] = 'hA; nv[5] = 'h9;
        job(2'b00, 0, 0, rnd(), rnd(), 0);
        step();
        for (int k = 0; k < NI; k++) nv[k] = rnd();
        nv[3] = 'hC; nv[4] = 'h11;
        job(2'b11, 0, 0, rnd(), rnd(), 0);
        do_reset("reset_idle");
        for (int k = 0; k < NI; k++) nv[k] = rnd();
        job(2'b11, 0, 0, 128'h0123456789ABCDEF0123456789ABCDEF,
            128'hFEDCBA9876543210FEDCBA9876543210, 0);
        for (int k = 0; k < NI; k++) nv[k] = rnd();
        job(2'b00, 5, 1, rnd(), rnd(), 0);
        do_reset("reset_idle2");
        job(2'b01, 0, 0, rnd(), rnd(), 1);
        for (int k = 0; k < NI; k++) nv[k] = rnd();
        job(2'b10, 1, 0, rnd(), rnd(), 0);
        job(2'b00, 2, 0, rnd(), rnd(), 2);
        for (int k = 0; k < NI; k++) nv[k] = rnd();
        job(2'b01, 0, 1, rnd(), rnd(), 0);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 5) == 0) do_reset("reset_rand");
            for (int k = 0; k < NI; k++) nv[k] = rnd();
            job(2'($urandom), $urandom_range(0, 3), 1'($urandom), rnd(), rnd(), 0);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (4) step();
        chk("op_queue_empty", 1024'(opq.size()), 1024'(0));
        chk("res_queue_empty", 1024'(resq.size()), 1024'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL timeout cycle=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
